peek_fifo_param: RTL and testbench
==================================

Name: peek_fifo_param

Overview:
Parametrised successor to the 6-bit peek FIFO: synchronous circular buffer with configurable data width and depth.
- Random-access peek into any occupied entry relative to the head.
- Occupancy count output.
- Synchronous flush.
- Sits between a byte-serial input mux and downstream consumer logic in the tile; one clock domain.

Parameters:
- WIDTH, 6, data word width in bits (1..32)
- DEPTH, 16, number of entries; must be a power of two (2..256)
- AW, $clog2(DEPTH), derived pointer/peek index width; not to be overridden

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of contents; keeps error flags
- wr_en  input  1  push wr_data this cycle
- wr_data  input  WIDTH  data to push
- pop  input  1  discard head entry this cycle
- peek  input  AW  offset from head to present on data_out (0 = head)
- data_out  output  WIDTH  entry at head+peek; 0 when peek invalid
- peek_valid  output  1  high when peek < count
- empty_n  output  1  high when count != 0
- ready  output  1  high when count != DEPTH (can accept a push)
- count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- State: mem[DEPTH] (not reset), rd_ptr[AW-1:0], wr_ptr[AW-1:0], count[AW:0].
- Reset (reset=1 at edge): rd_ptr=0, wr_ptr=0, count=0. Outputs: data_out=0, peek_valid=0, empty_n=0, ready=1, count=0. Reset dominates flush, wr_en and pop.
- Flush (flush=1, reset=0): same pointer/count clear as reset. wr_en/pop in the same cycle are ignored.
- Push accepted iff wr_en && (ready || pop_accepted). On accept: mem[wr_ptr]<=wr_data; wr_ptr<=wr_ptr+1, wrapping mod DEPTH.
- Pop accepted iff pop && empty_n. On accept: rd_ptr<=rd_ptr+1, wrapping mod DEPTH.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Full + push + pop: both accepted; count stays DEPTH. Old head is discarded and new data is written to the freed slot.
- Empty + push + pop: pop ignored, push accepted, count=1. No bypass; data is not visible on data_out until the next cycle.
- Push while full without pop: dropped, state unchanged.
- Pop while empty: ignored.
- Read path is combinational from registered state:
  - data_out = mem[(rd_ptr+peek) mod DEPTH] when peek_valid, else 0.
  - Written data is visible 1 cycle after the write edge.
- Status outputs are combinational decodes of count: empty_n, ready, peek_valid.
- Pointer wrap is handled purely by AW-bit overflow; no comparison logic on pointers.

Optional Feature:
Macro: PEEK_FIFO_ERR_FLAGS_EN
- Defined:
  - Adds input clr_err (1) and sticky outputs overflow (1) and underflow (1).
  - overflow is set on a dropped push; underflow is set on an ignored pop (pop while empty, including the empty+push+pop case).
  - Both flags are cleared by reset or clr_err. Set has priority over clr_err in the same cycle. Flush does not clear them.
- Undefined: the ports are absent and there is no extra logic.

Decomposition:
- Package peek_fifo_pkg:
  - Function fifo_aw(depth) returning $clog2.
  - Localparam checks: DEPTH power of two, WIDTH range, asserted in an initial block under simulation.
- Sub-module fifo_wrap_ptr (params AW):
  - Inputs clk, reset, clr, inc; output ptr.
  - Instantiated twice for rd_ptr and wr_ptr.
- Storage, count and read mux stay in the top module.

Test Plan:
- Reset then idle → count=0, empty_n=0, ready=1, peek_valid=0, data_out=0.
- Push 0x01..0x10 (DEPTH=16) → after the 16th push: count=16, ready=0. Peek 0..15 returns 0x01..0x10. A 17th push of 0x3F is dropped (count stays 16; overflow=1 with macro).
- Full: push 0x2A with pop in the same cycle → count=16, peek 0 = 0x02, peek 15 = 0x2A.
- Pop 20 times from 3 entries → count 0 after the 3rd pop; later pops change nothing (underflow=1 with macro). Then push 0x05 with pop on empty → count=1, data_out (peek 0) = 0x05 next cycle.
- Wrap: run 40 push/pop pairs with data = index → each cycle data_out at peek 0 equals the expected sequence across pointer wrap. Peek ≥ count gives data_out=0 and peek_valid=0.
- Assert flush mid-stream with wr_en=1 and count=7 → count=0, no write. Assert reset and flush together → reset values. Error flags survive flush and clear on clr_err.

Source files
------------

// File: rtl/peek_fifo_param_pkg.sv
// Shared types, limits and helpers for the parametrised peek FIFO.
package peek_fifo_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 256;

  // Accepted-operation pair {push, pop} as seen by the occupancy counter.
  typedef enum logic [1:0] {
    FIFO_OP_NONE = 2'b00,
    FIFO_OP_POP  = 2'b01,
    FIFO_OP_PUSH = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit fifo_params_ok(input int width, input int depth);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/peek_fifo_param_wrap_ptr.sv
// Free-running circular pointer; wraps by natural AW-bit overflow.
module fifo_wrap_ptr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = {AW{1'b0}};
    end else if (inc) begin
      ptr_d = ptr_q + AW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= {AW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/peek_fifo_param.sv
// Circular-buffer FIFO with random-access peek relative to the head.
// Optional sticky overflow/underflow flags via PEEK_FIFO_ERR_FLAGS_EN.
module peek_fifo_param
  import peek_fifo_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16,
  parameter int AW    = fifo_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic [AW-1:0]    peek,
  output logic [WIDTH-1:0] data_out,
  output logic             peek_valid,
  output logic             empty_n,
  output logic             ready,
`ifdef PEEK_FIFO_ERR_FLAGS_EN
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [AW-1:0]    rd_ptr_s;
  logic [AW-1:0]    wr_ptr_s;
  logic [AW-1:0]    rd_idx_s;
  logic             pop_ok_s;
  logic             push_ok_s;
  fifo_op_e         op_s;

  assign empty_n    = (count_q != {(AW+1){1'b0}});
  assign ready      = (count_q != FULL_CNT);
  assign peek_valid = ({1'b0, peek} < count_q);

  // A pop frees the slot a simultaneous push needs, so full+push+pop is legal.
  assign pop_ok_s  = pop && empty_n && !flush;
  assign push_ok_s = wr_en && (ready || pop_ok_s) && !flush;
  assign op_s      = fifo_op_e'({push_ok_s, pop_ok_s});

  fifo_wrap_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (pop_ok_s),
    .ptr   (rd_ptr_s)
  );

  fifo_wrap_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (push_ok_s),
    .ptr   (wr_ptr_s)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {(AW+1){1'b0}};
    end else begin
      case (op_s)
        FIFO_OP_PUSH: count_d = count_q + (AW+1)'(1);
        FIFO_OP_POP:  count_d = count_q - (AW+1)'(1);
        default:      count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {(AW+1){1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; invalid entries are masked by peek_valid.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_q[wr_ptr_s] <= wr_data;
    end
  end

  assign rd_idx_s = rd_ptr_s + peek;

  always_comb begin
    data_out = {WIDTH{1'b0}};
    if (peek_valid) begin
      data_out = mem_q[rd_idx_s];
    end else begin
      data_out = {WIDTH{1'b0}};
    end
  end

  assign count = count_q;

`ifdef PEEK_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;
  logic ovf_set_s;
  logic unf_set_s;

  assign ovf_set_s = wr_en && !ready && !pop_ok_s && !flush;
  assign unf_set_s = pop && !empty_n && !flush;

  // Set wins over clear so an event coinciding with clr_err is never lost.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (unf_set_s) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_peek_fifo_param.sv
// Self-checking bench for peek_fifo_param against a queue-based reference model.
module tb_peek_fifo_param;
  import peek_fifo_pkg::*;

  localparam int WIDTH = 6;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             pop;
  logic [AW-1:0]    peek;
  logic [WIDTH-1:0] data_out;
  logic             peek_valid;
  logic             empty_n;
  logic             ready;
  logic [AW:0]      count;
`ifdef PEEK_FIFO_ERR_FLAGS_EN
  logic             clr_err;
  logic             overflow;
  logic             underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  bit               m_ov;
  bit               m_un;

  always #5 clk = ~clk;

  peek_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .pop        (pop),
    .peek       (peek),
    .data_out   (data_out),
    .peek_valid (peek_valid),
    .empty_n    (empty_n),
    .ready      (ready),
`ifdef PEEK_FIFO_ERR_FLAGS_EN
    .clr_err    (clr_err),
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .count      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded queue plus sticky flags.
  task automatic model(input logic w, input logic [WIDTH-1:0] d, input logic p,
                       input logic f, input logic r, input logic c);
    bit set_ov;
    bit set_un;
    bit pop_ok;
    bit push_ok;
    set_ov = 1'b0;
    set_un = 1'b0;
    if (r) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (f) begin
        q.delete();
      end else begin
        pop_ok  = p && (q.size() > 0);
        push_ok = w && ((q.size() < DEPTH) || pop_ok);
        set_ov  = w && !push_ok;
        set_un  = p && (q.size() == 0);
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
      end
      m_ov = set_ov ? 1'b1 : (c ? 1'b0 : m_ov);
      m_un = set_un ? 1'b1 : (c ? 1'b0 : m_un);
    end
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic p,
                      input logic f, input logic r, input logic c);
    wr_en   = w;
    wr_data = d;
    pop     = p;
    flush   = f;
    reset   = r;
`ifdef PEEK_FIFO_ERR_FLAGS_EN
    clr_err = c;
`endif
    @(posedge clk);
    model(w, d, p, f, r, c);
    #1;
    wr_en   = 1'b0;
    wr_data = '0;
    pop     = 1'b0;
    flush   = 1'b0;
    reset   = 1'b0;
`ifdef PEEK_FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif
  endtask

  task automatic check_state(input string tag, input logic [AW-1:0] pk);
    logic [WIDTH-1:0] exp_d;
    peek = pk;
    #1;
    exp_d = (int'(pk) < q.size()) ? q[pk] : '0;
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty_n"}, 32'(empty_n), 32'(q.size() != 0));
    chk({tag, "_ready"}, 32'(ready), 32'(q.size() != DEPTH));
    chk({tag, "_peek_valid"}, 32'(peek_valid), 32'(int'(pk) < q.size()));
    chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
`ifdef PEEK_FIFO_ERR_FLAGS_EN
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, "_unf"}, 32'(underflow), 32'(m_un));
`endif
  endtask

  initial begin
    int wp;
    logic [AW-1:0] pk;
    if (!fifo_params_ok(WIDTH, DEPTH)) begin
      $display("FAIL params WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
      $fatal(1, "bad parameters");
    end
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; pop = 1'b0; wr_data = '0; peek = '0;
`ifdef PEEK_FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif

    // Reset then idle.
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("reset_p0", 4'd0);
    chk("reset_data_lit", 32'(data_out), 32'h0);
    chk("reset_count_lit", 32'(count), 32'd0);
    check_state("reset_p5", 4'd5);

    // Fill with 0x01..0x10 and peek every slot.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 6'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count_lit", 32'(count), 32'd16);
    chk("full_ready_lit", 32'(ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check_state("full_peek", 4'(i));
      chk("full_peek_lit", 32'(data_out), 32'(i + 1));
    end

    // Dropped push while full.
    step(1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("drop_p15", 4'd15);
    chk("drop_data_lit", 32'(data_out), 32'h10);

    // Full push+pop.
    step(1'b1, 6'h2A, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("fullpp_p0", 4'd0);
    chk("fullpp_p0_lit", 32'(data_out), 32'h02);
    check_state("fullpp_p15", 4'd15);
    chk("fullpp_p15_lit", 32'(data_out), 32'h2A);

    // Drain to 3 entries, then pop 20 times.
    for (int i = 0; i < 13; i++) step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("three_left", 4'd2);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check_state("underpop", 4'd0);
    end
    chk("underpop_count_lit", 32'(count), 32'd0);

    // Push+pop on empty: pop ignored, value visible next cycle.
    step(1'b1, 6'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("emptypp", 4'd0);
    chk("emptypp_data_lit", 32'(data_out), 32'h05);
    chk("emptypp_count_lit", 32'(count), 32'd1);

    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_state("clr_err", 4'd0);

    // 40 push/pop pairs across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 6'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      check_state("wrap_p0", 4'd0);
      check_state("wrap_p1", 4'd1);
    end

    // Randomized traffic with alternating fill bias.
    for (int i = 0; i < 400; i++) begin
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 99) < wp), 6'($urandom), ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 99) < 2), 1'b0, ($urandom_range(0, 99) < 5));
      pk = 4'($urandom);
      check_state("rand", pk);
    end

    // Set underflow, build to 7 entries, flush with a push pending.
    while (q.size() > 0) step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 6'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("pre_flush", 4'd6);
    step(1'b1, 6'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("flush", 4'd0);
    chk("flush_count_lit", 32'(count), 32'd0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("post_flush", 4'd0);

    // Reset and flush together.
    step(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'h02, 1'b1, 1'b1, 1'b1, 1'b0);
    check_state("reset_flush", 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
